// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame_ctrl
// Brief    : UART transmit serialiser with runtime parity, 1/2 stop bits and
//            back-to-back frames; one clock per bit period.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame_ctrl #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              baud_rate_tx,
    input  logic              rst_n,
    input  logic              tx_enable,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              parity_en,
    input  logic              parity_odd,
    output logic              tx_out,
    output logic              busy,
    output logic              load,
    output logic              shift,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_last_data = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_last_stop = CNT_W'(STOP_BITS - 1);
    localparam bit               c_one_stop  = (STOP_BITS == 1);
    localparam int               c_end_idx   = MSB_FIRST ? DATA_W - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_shreg;
    logic                r_par_en;
    logic                r_par_bit;

    logic [DATA_W-1:0]   w_shreg_next;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_end_bit;
    logic                w_start_frame;

    assign w_shreg_next = MSB_FIRST ? {r_shreg[DATA_W-2:0], 1'b0}
                                    : {1'b0, r_shreg[DATA_W-1:1]};
    assign w_end_bit    = r_shreg[c_end_idx];
    assign w_cnt_inc    = r_cnt + CNT_W'(1);

    // A request is honoured in IDLE and on the exit edge of the last stop bit.
    assign w_start_frame = tx_enable &&
                           ((r_state == S_IDLE) ||
                            ((r_state == S_STOP) && (r_cnt == c_last_stop)));

    always_ff @(posedge baud_rate_tx or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            load      <= 1'b0;
            shift     <= 1'b0;
            done      <= 1'b0;
        end else begin
            load  <= 1'b0;
            shift <= 1'b0;
            done  <= 1'b0;
            if (w_start_frame) begin
                r_state   <= S_START;
                r_cnt     <= '0;
                r_shreg   <= tx_data;
                r_par_en  <= parity_en;
                r_par_bit <= (^tx_data) ^ parity_odd;
                tx_out    <= 1'b0;
                busy      <= 1'b1;
                load      <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                    end
                    S_START: begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                        tx_out  <= w_end_bit;
                        r_shreg <= w_shreg_next;
                        shift   <= 1'b1;
                    end
                    S_DATA: begin
                        if (r_cnt == c_last_data) begin
                            r_cnt <= '0;
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                tx_out  <= r_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                tx_out  <= 1'b1;
                                done    <= c_one_stop;
                            end
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            tx_out  <= w_end_bit;
                            r_shreg <= w_shreg_next;
                            shift   <= 1'b1;
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_cnt   <= '0;
                        tx_out  <= 1'b1;
                        done    <= c_one_stop;
                    end
                    S_STOP: begin
                        tx_out <= 1'b1;
                        if (r_cnt == c_last_stop) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            busy    <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            done  <= (w_cnt_inc == c_last_stop);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        tx_out  <= 1'b1;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame_ctrl
// Brief    : Directed self-checking bench for uart_tx_frame_ctrl (default and
//            DATA_W=5 / STOP_BITS=2 / MSB-first instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_enable, tx_enable2;
    logic [7:0] tx_data;
    logic [4:0] tx_data2;
    logic       parity_en, parity_odd;
    logic       tx_out_a, busy_a, load_a, shift_a, done_a;
    logic       tx_out_b, busy_b, load_b, shift_b, done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl u_dut_a (
        .baud_rate_tx (clk),
        .rst_n        (rst_n),
        .tx_enable    (tx_enable),
        .tx_data      (tx_data),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .tx_out       (tx_out_a),
        .busy         (busy_a),
        .load         (load_a),
        .shift        (shift_a),
        .done         (done_a)
    );

    uart_tx_frame_ctrl #(
        .DATA_W    (5),
        .STOP_BITS (2),
        .MSB_FIRST (1'b1)
    ) u_dut_b (
        .baud_rate_tx (clk),
        .rst_n        (rst_n),
        .tx_enable    (tx_enable2),
        .tx_data      (tx_data2),
        .parity_en    (1'b0),
        .parity_odd   (1'b0),
        .tx_out       (tx_out_b),
        .busy         (busy_b),
        .load         (load_b),
        .shift        (shift_b),
        .done         (done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input bit sel, input string tag, input logic e_tx, input logic e_busy,
                        input logic e_load, input logic e_shift, input logic e_done);
        chk({tag, " tx_out"}, sel ? tx_out_b : tx_out_a, e_tx);
        chk({tag, " busy"},   sel ? busy_b   : busy_a,   e_busy);
        chk({tag, " load"},   sel ? load_b   : load_a,   e_load);
        chk({tag, " shift"},  sel ? shift_b  : shift_a,  e_shift);
        chk({tag, " done"},   sel ? done_b   : done_a,   e_done);
    endtask

    task automatic idle(input bit sel, input string tag);
        @(negedge clk);
        outs(sel, tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Checks one frame period by period; seq[i] is the expected line level in period i.
    task automatic frame(input bit sel, input logic [11:0] seq, input int len, input int nbits,
                         input int pulse_idx, input int drop_idx, input logic [7:0] next_data,
                         input string tag);
        logic [11:0] s;
        s = seq;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            outs(sel, $sformatf("%s p%0d", tag, i), s[i], 1'b1, (i == 0),
                 (i >= 1 && i <= nbits), (i == len - 1));
            if (i == 0) begin
                if (sel) tx_data2 = next_data[4:0];
                else     tx_data  = next_data;
            end
            if (i == pulse_idx) begin
                if (sel) tx_enable2 = 1'b1;
                else     tx_enable  = 1'b1;
            end
            if (i == drop_idx) begin
                if (sel) tx_enable2 = 1'b0;
                else     tx_enable  = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        tx_enable  = 1'b0;
        tx_enable2 = 1'b0;
        tx_data    = 8'h00;
        tx_data2   = 5'h00;
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        outs(0, "rst_a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        outs(1, "rst_b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle(0, "idle_a");

        // Basic frame 8'hA5, no parity
        tx_data   = 8'hA5;
        tx_enable = 1'b1;
        frame(0, 12'h34A, 10, 8, -1, 0, 8'hA5, "a5");
        idle(0, "a5_idle");

        // Parity even then odd on 8'h07
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        tx_data    = 8'h07;
        tx_enable  = 1'b1;
        frame(0, 12'h60E, 11, 8, -1, 0, 8'h07, "par_even");
        parity_odd = 1'b1;
        tx_enable  = 1'b1;
        frame(0, 12'h40E, 11, 8, -1, 0, 8'h07, "par_odd");
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        idle(0, "par_idle");

        // Back-to-back 8'h55 then 8'hFF with tx_enable held
        tx_data   = 8'h55;
        tx_enable = 1'b1;
        frame(0, 12'h2AA, 10, 8, -1, -1, 8'hFF, "b2b1");
        frame(0, 12'h3FE, 10, 8, -1, 0, 8'hFF, "b2b2");
        idle(0, "b2b_idle");

        // Async reset during data bit 4
        tx_data   = 8'hA5;
        tx_enable = 1'b1;
        @(negedge clk);
        chk("rstmid load", load_a, 1'b1);
        tx_enable = 1'b0;
        repeat (5) @(negedge clk);
        chk("rstmid bit4 tx", tx_out_a, 1'b0);
        chk("rstmid bit4 shift", shift_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid async tx", tx_out_a, 1'b1);
        chk("rstmid async busy", busy_a, 1'b0);
        chk("rstmid async shift", shift_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(0, "rstmid_idle");
        tx_data   = 8'hA5;
        tx_enable = 1'b1;
        frame(0, 12'h34A, 10, 8, -1, 0, 8'hA5, "rstmid_re");
        idle(0, "rstmid_re_idle");

        // Disturbance: data change and tx_enable pulse mid-frame
        tx_data   = 8'h3C;
        tx_enable = 1'b1;
        frame(0, 12'h278, 10, 8, 3, 4, 8'hC3, "dist");
        idle(0, "dist_idle1");
        idle(0, "dist_idle2");

        // DATA_W=5, STOP_BITS=2, MSB first
        tx_data2   = 5'b10110;
        tx_enable2 = 1'b1;
        frame(1, 12'h0DA, 8, 5, -1, 0, 8'h16, "w5");
        idle(1, "w5_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
